// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: FSM states,
// opcodes and the datapath select encodings also used by the ALU control decoder.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
    localparam logic [1:0] RESULT_DATA      = 2'b01;
    localparam logic [1:0] RESULT_ALURESULT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LOAD)  || (op == OP_STORE)  || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Immediate format select, decoded purely from the opcode field.
module instr_decoder
    import riscv_mc_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback with a memory ready handshake.
module multicycle_controller
    import riscv_mc_pkg::*;
#(
    parameter bit RESET_STATE_FETCH = 1'b1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic       illegal_instr
);

    // The reserved setting 0 has no alternative start state, so it also lands in FETCH.
    localparam state_t RESET_STATE = RESET_STATE_FETCH ? FETCH : FETCH;

    state_t state;
    state_t next_state;
    state_t cur_state;
    logic   illegal_next;

    instr_decoder u_instr_decoder (
        .op      (op),
        .imm_src (imm_src)
    );

    // Outputs already show FETCH values while reset is held, before the edge lands.
    assign cur_state = rst_n ? state : FETCH;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RESET_STATE;
            illegal_instr <= 1'b0;
        end else begin
            state         <= next_state;
            illegal_instr <= illegal_next;
        end
    end

    always_comb begin
        next_state   = FETCH;
        illegal_next = 1'b0;
        mem_req      = 1'b0;
        pc_write     = 1'b0;
        adr_src      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        result_src   = RESULT_ALUOUT;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_OP_ADD;
        reg_write    = 1'b0;

        case (cur_state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RESULT_ALURESULT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (op)
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    OP_RTYPE:          next_state = EXECUTER;
                    OP_ITYPE:          next_state = EXECUTEI;
                    OP_BRANCH:         next_state = BEQ;
                    OP_JAL:            next_state = JAL;
                    default:           next_state = FETCH;
                endcase
                illegal_next = !is_supported(op);
            end
            MEMADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                next_state = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                next_state = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = RESULT_DATA;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                next_state = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALU_OP_FUNCT;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_OP_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            BEQ: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_OP_SUB;
                pc_write  = zero;
            end
            JAL: begin
                // PC loads the target precomputed in DECODE while the ALU forms the link.
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                pc_write   = 1'b1;
                next_state = ALUWB;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded into
// a table of per-cycle expected outputs and walked alongside the DUT.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    localparam logic [1:0] PC_NONE   = 2'd0;
    localparam logic [1:0] PC_READY  = 2'd1;
    localparam logic [1:0] PC_ZERO   = 2'd2;
    localparam logic [1:0] PC_ALWAYS = 2'd3;

    typedef struct packed {
        logic       memReq;
        logic       adrSrc;
        logic       memWrite;
        logic       regWrite;
        logic [1:0] resultSrc;
        logic [1:0] srcA;
        logic [1:0] srcB;
        logic [1:0] aluOp;
        logic [1:0] pcKind;
        logic       irOnReady;
        logic       waitsMem;
    } step_t;

    typedef struct {
        logic [6:0] op;
        int         fetchStall;
        int         memStall;
        logic       zeroVal;
        int         rstAt;
    } instr_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] imm_src;
    logic       illegal_instr;

    int     compared;
    int     mismatched;
    step_t  steps[$];
    instr_t prog[$];
    instr_t cur;
    int     pos;
    int     waited;
    int     cycles;
    logic   illNow;
    logic   done;

    multicycle_controller #(.RESET_STATE_FETCH(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .imm_src       (imm_src),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic step_t mkStep(input logic req, input logic adr, input logic mw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] ao, input logic [1:0] pk, input logic irr,
                                     input logic wm);
        step_t s;
        s = '{memReq: req, adrSrc: adr, memWrite: mw, regWrite: rw, resultSrc: rs, srcA: a,
              srcB: b, aluOp: ao, pcKind: pk, irOnReady: irr, waitsMem: wm};
        return s;
    endfunction

    function automatic step_t fetchStep();
        return mkStep(1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, PC_READY, 1, 1);
    endfunction

    function automatic logic [1:0] immFor(input logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BQ) return 2'b10;
        if (o == JL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic isLegal(input logic [6:0] o);
        return o inside {LW, SW, RT, IT, BQ, JL};
    endfunction

    function automatic int baseLat(input logic [6:0] o);
        case (o)
            LW:      return 5;
            SW, RT, IT, JL: return 4;
            BQ:      return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [16:0] expVec(input step_t s, input logic rdy, input logic z,
                                           input logic [6:0] o, input logic ill);
        logic pcw;
        case (s.pcKind)
            PC_READY:  pcw = rdy;
            PC_ZERO:   pcw = z;
            PC_ALWAYS: pcw = 1'b1;
            default:   pcw = 1'b0;
        endcase
        return {s.memReq, pcw, s.adrSrc, s.memWrite, s.irOnReady & rdy, s.resultSrc,
                s.srcA, s.srcB, s.aluOp, s.regWrite, immFor(o), ill};
    endfunction

    function automatic logic [16:0] actVec();
        return {mem_req, pc_write, adr_src, mem_write, ir_write, result_src,
                alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal_instr};
    endfunction

    task automatic buildSteps(input logic [6:0] o);
        steps.delete();
        steps.push_back(fetchStep());
        steps.push_back(mkStep(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, PC_NONE, 0, 0));
        case (o)
            LW: begin
                steps.push_back(mkStep(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, PC_NONE, 0, 0));
                steps.push_back(mkStep(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, PC_NONE, 0, 1));
                steps.push_back(mkStep(0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, PC_NONE, 0, 0));
            end
            SW: begin
                steps.push_back(mkStep(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, PC_NONE, 0, 0));
                steps.push_back(mkStep(1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, PC_NONE, 0, 1));
            end
            RT, IT: begin
                steps.push_back(mkStep(0, 0, 0, 0, 2'b00, 2'b10, (o == IT) ? 2'b01 : 2'b00, 2'b10,
                                       PC_NONE, 0, 0));
                steps.push_back(mkStep(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, PC_NONE, 0, 0));
            end
            BQ: steps.push_back(mkStep(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, PC_ZERO, 0, 0));
            JL: begin
                steps.push_back(mkStep(0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, PC_ALWAYS, 0, 0));
                steps.push_back(mkStep(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, PC_NONE, 0, 0));
            end
            default: ;
        endcase
    endtask

    task automatic startNext();
        if (prog.size() == 0) begin
            done = 1'b1;
        end else begin
            cur = prog.pop_front();
            buildSteps(cur.op);
            pos    = 0;
            waited = 0;
            cycles = 0;
        end
    endtask

    // One clock of stimulus, comparison against the step table, then model advance.
    task automatic applyStimulus();
        step_t s;
        logic  doRst;
        logic  illNext;
        int    limit;
        @(negedge clk);
        s = steps[pos];
        if (s.waitsMem) begin
            limit     = (pos == 0) ? cur.fetchStall : cur.memStall;
            mem_ready = (waited >= limit);
        end else begin
            mem_ready = 1'($urandom);
        end
        doRst = (cur.rstAt > 0) && (pos != 0) && s.waitsMem && (waited == cur.rstAt);
        rst_n = !doRst;
        op    = (pos == 0) ? 7'($urandom) : cur.op;
        zero  = (s.pcKind == PC_ZERO) ? cur.zeroVal : 1'($urandom);
        #1;
        if (doRst) begin
            checkOutput("reset_mid", 32'(actVec()), 32'(expVec(fetchStep(), mem_ready, zero, op, illNow)));
            illNow = 1'b0;
            startNext();
        end else begin
            checkOutput($sformatf("op%b_step%0d", cur.op, pos), 32'(actVec()),
                        32'(expVec(s, mem_ready, zero, op, illNow)));
            cycles++;
            illNext = 1'b0;
            if (s.waitsMem && !mem_ready) begin
                waited++;
            end else if (pos == steps.size() - 1) begin
                illNext = !isLegal(cur.op);
                checkOutput($sformatf("latency_op%b", cur.op), 32'(cycles),
                            32'(baseLat(cur.op) + cur.fetchStall +
                                ((cur.op == LW || cur.op == SW) ? cur.memStall : 0)));
                startNext();
            end else begin
                pos++;
                waited = 0;
            end
            illNow = illNext;
        end
    endtask

    task automatic addInstr(input logic [6:0] o, input int fs, input int ms, input logic z, input int ra);
        instr_t d;
        d = '{op: o, fetchStall: fs, memStall: ms, zeroVal: z, rstAt: ra};
        prog.push_back(d);
    endtask

    initial begin
        logic [6:0] legalOps [6];
        int         guard;
        compared   = 0;
        mismatched = 0;
        done       = 1'b0;
        illNow     = 1'b0;
        legalOps   = '{LW, SW, RT, IT, BQ, JL};

        rst_n     = 1'b0;
        op        = LW;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_hold_rdy0", 32'(actVec()), 32'(expVec(fetchStep(), 1'b0, zero, op, 1'b0)));
        mem_ready = 1'b1;
        op        = JL;
        #1;
        checkOutput("reset_hold_rdy1", 32'(actVec()), 32'(expVec(fetchStep(), 1'b1, zero, op, 1'b0)));

        addInstr(LW,  0, 0, 0, 0);
        addInstr(SW,  0, 3, 0, 0);
        addInstr(BQ,  0, 0, 1, 0);
        addInstr(BQ,  0, 0, 0, 0);
        addInstr(RT,  0, 0, 0, 0);
        addInstr(IT,  0, 0, 0, 0);
        addInstr(JL,  0, 0, 0, 0);
        addInstr(BAD, 0, 0, 0, 0);
        addInstr(LW,  2, 1, 0, 0);
        addInstr(LW,  0, 20, 0, 2);
        addInstr(SW,  1, 0, 0, 0);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0)
                addInstr(7'($urandom), $urandom_range(0, 3), 0, 1'($urandom), 0);
            else
                addInstr(legalOps[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3),
                         1'($urandom), 0);
        end

        startNext();
        guard = 0;
        while (!done && guard < 5000) begin
            applyStimulus();
            guard++;
        end
        if (!done) checkOutput("cycle_budget", 32'(guard), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multi-cycle RV32I core variant: sequences the shared ALU, register file and unified memory over several cycles per instruction. Decodes opcode and emits per-state datapath selects plus ALUOp, which the existing ALU control decoder turns into ALUControl. Adds a memory ready handshake so fetch and data accesses can stall. Supports lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
RESET_STATE_FETCH, 1, if 1 the FSM leaves reset in FETCH; 0 is reserved and unsupported.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
op  input  7  instr[6:0] from the instruction register
zero  input  1  ALU zero flag, valid in BEQ state
mem_ready  input  1  memory completes access this cycle
mem_req  output  1  memory access request
pc_write  output  1  PC register enable
adr_src  output  1  memory address: 0=PC, 1=ALUOut/Result
mem_write  output  1  store strobe, qualified by mem_req
ir_write  output  1  IR and OldPC enable
result_src  output  2  00=ALUOut, 01=Data, 10=ALUResult
alu_src_a  output  2  00=PC, 01=OldPC, 10=rs1 data
alu_src_b  output  2  00=rs2 data, 01=ImmExt, 10=constant 4
alu_op  output  2  00=add, 01=sub, 10=funct-decoded
reg_write  output  1  register file write enable
imm_src  output  2  00=I, 01=S, 10=B, 11=J
illegal_instr  output  1  one-cycle pulse on unsupported opcode

Behaviour:
- Moore FSM. All outputs except pc_write, ir_write and imm_src decode from the state register only. pc_write and ir_write also depend on mem_ready and zero. imm_src decodes from op only.
- Reset: rst_n=0 at a rising edge forces state=FETCH, which overrides any in-flight state. While reset is asserted and in the first cycle after it, outputs carry FETCH values. illegal_instr is registered and clears to 0 on reset.
- Default output value is 0 unless listed below. The default for alu_op is 00.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=mem_ready, pc_write=mem_ready.
  - mem_ready=0: stay in FETCH with no PC or IR update.
  - mem_ready=1: go to DECODE.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00. This precomputes the branch/jal target.
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other opcode -> FETCH, with illegal_instr=1 in the next cycle only.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next is FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Hold until mem_ready=1, then go to FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next is ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next is ALUWB.
- ALUWB: result_src=00, reg_write=1. Next is FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. Next is FETCH.
- JAL:
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
  - The PC takes the target from ALUOut; the ALU computes OldPC+4 for the link.
  - Next is ALUWB.
- Latency with mem_ready=1 throughout, in cycles: lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2. Each cycle of mem_ready=0 in a memory state adds one cycle.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- Unreachable state encodings recover to FETCH on the next edge.

Decomposition:
- Shared package riscv_mc_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, in 4 bits;
  - opcode constants;
  - alu_op, result_src, alu_src_a and alu_src_b encodings, also used by the ALU control decoder.
- One sub-module, instr_decoder, gives the combinational op to imm_src mapping.

Test Plan:
- Reset hold, then rst_n=1 with op=0000011 and mem_ready=1 constant -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 only in cycle 5 with result_src=01.
- sw with mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 and mem_req=1 held for 4 cycles, then FETCH. pc_write=0 throughout the stall.
- beq with zero=1 -> pc_write=1 in cycle 3 with alu_op=01. Repeat with zero=0 -> pc_write=0. Both cases return to FETCH.
- R-type, then I-type, then jal -> alu_op=10 in EXECUTER and EXECUTEI. jal gives pc_write=1 in JAL, then ALUWB with reg_write=1. imm_src reads 00 for I-type and 11 for jal.
- op=1111111 in DECODE -> FETCH next cycle with illegal_instr=1 for exactly 1 cycle. No reg_write or mem_write is ever asserted.
- rst_n=0 asserted while in MEMREAD during a stall -> FETCH on the next edge. Outputs match FETCH values and mem_write stays 0.
